// File: rtl/fir_core_if.sv
// Signal bundle between fir_core and its neighbours: config block handshake,
// tap coefficient port, AXI-Stream in/out and the data history BRAM.
interface fir_core_if #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11,
  parameter int unsigned RAM_ADDR    = $clog2(Tape_Num)
);
  logic                   ap_start;
  logic                   ap_idle;
  logic                   ap_done;
  logic [pDATA_WIDTH-1:0] data_length;
  logic [RAM_ADDR-1:0]    tap_raddr;
  logic [pDATA_WIDTH-1:0] tap_rdata;
  logic                   ss_tvalid;
  logic [pDATA_WIDTH-1:0] ss_tdata;
  logic                   ss_tlast;
  logic                   ss_tready;
  logic                   sm_tvalid;
  logic [pDATA_WIDTH-1:0] sm_tdata;
  logic                   sm_tlast;
  logic                   sm_tready;
  logic [3:0]             data_WE;
  logic                   data_EN;
  logic [pDATA_WIDTH-1:0] data_Di;
  logic [pADDR_WIDTH-1:0] data_A;
  logic [pDATA_WIDTH-1:0] data_Do;

  // Core side
  modport slave (
    input  ap_start, data_length, tap_rdata, ss_tvalid, ss_tdata, ss_tlast, sm_tready, data_Do,
    output ap_idle, ap_done, tap_raddr, ss_tready, sm_tvalid, sm_tdata, sm_tlast,
           data_WE, data_EN, data_Di, data_A
  );

  // Environment side (config block, stream peers, BRAM)
  modport master (
    output ap_start, data_length, tap_rdata, ss_tvalid, ss_tdata, ss_tlast, sm_tready, data_Do,
    input  ap_idle, ap_done, tap_raddr, ss_tready, sm_tvalid, sm_tdata, sm_tlast,
           data_WE, data_EN, data_Di, data_A
  );
endinterface

// File: rtl/fir_core.sv
// Sequential FIR: one Tape_Num-tap MAC per streamed sample, history kept in a
// circular data BRAM that is zeroed at the start of every run.
module fir_core #(
  parameter int unsigned pADDR_WIDTH = 12,
  parameter int unsigned pDATA_WIDTH = 32,
  parameter int unsigned Tape_Num    = 11,
  parameter int unsigned RAM_ADDR    = $clog2(Tape_Num)
) (
  input logic       axis_clk,
  input logic       axis_rst_n,
  fir_core_if.slave bus
);
  // One extra bit so the MAC counter can reach Tape_Num itself
  localparam int unsigned CntW = RAM_ADDR + 1;
  localparam logic [CntW-1:0] NumTaps = CntW'(Tape_Num);
  localparam logic [CntW-1:0] LastTap = CntW'(Tape_Num - 1);
  localparam logic [RAM_ADDR-1:0] PtrLast = RAM_ADDR'(Tape_Num - 1);

  typedef enum logic [2:0] {StIdle, StClear, StWaitIn, StMac, StOut, StDone} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        k_q, k_d;
  logic [RAM_ADDR-1:0]    ptr_q, ptr_d;
  logic [pDATA_WIDTH-1:0] count_q, count_d;
  logic [pDATA_WIDTH-1:0] len_q, len_d;
  logic [pDATA_WIDTH-1:0] acc_q, acc_d;
  logic [pDATA_WIDTH-1:0] count_inc;
  logic [pDATA_WIDTH-1:0] prod_lo;
  logic [CntW-1:0]        ptr_ext;
  logic [CntW-1:0]        data_idx;

  assign count_inc = count_q + pDATA_WIDTH'(1);
  assign ptr_ext   = {1'b0, ptr_q};
  // Low word of a two's-complement product is identical for signed and unsigned
  // operands, so the wrapping accumulate only needs these bits.
  assign prod_lo   = $signed(bus.tap_rdata) * $signed(bus.data_Do);

  // State and datapath registers
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q <= StIdle;
      k_q     <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      len_q   <= len_d;
      acc_q   <= acc_d;
    end
  end

  // Next-state, datapath updates and all outputs
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    ptr_d         = ptr_q;
    count_d       = count_q;
    len_d         = len_q;
    acc_d         = acc_q;
    data_idx      = '0;
    bus.ap_idle   = 1'b0;
    bus.ap_done   = 1'b0;
    bus.ss_tready = 1'b0;
    bus.sm_tvalid = 1'b0;
    bus.sm_tlast  = 1'b0;
    bus.data_EN   = 1'b0;
    bus.data_WE   = 4'h0;
    bus.data_Di   = '0;
    bus.tap_raddr = '0;

    unique case (state_q)
      StIdle: begin
        bus.ap_idle = 1'b1;
        if (bus.ap_start) begin
          len_d   = bus.data_length;
          k_d     = '0;
          state_d = StClear;
        end
      end
      StClear: begin
        bus.data_EN = 1'b1;
        bus.data_WE = 4'hF;
        data_idx    = k_q;
        if (k_q == LastTap) begin
          k_d     = '0;
          ptr_d   = '0;
          count_d = '0;
          state_d = (len_q == '0) ? StDone : StWaitIn;
        end else begin
          k_d = k_q + CntW'(1);
        end
      end
      StWaitIn: begin
        bus.ss_tready = 1'b1;
        bus.data_EN   = 1'b1;
        bus.data_Di   = bus.ss_tdata;
        data_idx      = ptr_ext;
        if (bus.ss_tvalid) begin
          bus.data_WE = 4'hF;
          k_d         = '0;
          acc_d       = '0;
          state_d     = StMac;
        end
      end
      StMac: begin
        // Reads issued for k < N; their data lands one cycle later
        if (k_q != NumTaps) begin
          bus.tap_raddr = k_q[RAM_ADDR-1:0];
          bus.data_EN   = 1'b1;
          data_idx      = (ptr_ext >= k_q) ? ptr_ext - k_q : ptr_ext + NumTaps - k_q;
        end
        if (k_q != '0) acc_d = acc_q + prod_lo;
        if (k_q == NumTaps) state_d = StOut;
        else                k_d     = k_q + CntW'(1);
      end
      StOut: begin
        bus.sm_tvalid = 1'b1;
        bus.sm_tlast  = (count_q == len_q - pDATA_WIDTH'(1));
        if (bus.sm_tready) begin
          ptr_d   = (ptr_q == PtrLast) ? '0 : ptr_q + RAM_ADDR'(1);
          count_d = count_inc;
          state_d = (count_inc == len_q) ? StDone : StWaitIn;
        end
      end
      StDone: begin
        bus.ap_done = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase

    bus.data_A = pADDR_WIDTH'({data_idx, 2'b00});
  end

  assign bus.sm_tdata = acc_q;
endmodule

// File: tb/tb_fir_core.sv
// Randomised self-checking bench for fir_core with BRAM/tap-port models and a
// direct-form convolution reference.
module tb_fir_core;
  localparam int N = 11;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fir_core_if bus ();
  fir_core dut (.axis_clk(clk), .axis_rst_n(rst_n), .bus(bus));

  logic [31:0] tap_mem [16];
  logic [31:0] data_mem [16];
  logic [31:0] in_v [$];
  logic [31:0] got_q [$];
  bit          last_q [$];
  int          hs_in_cyc [$];
  int          done_cnt, first_valid_cyc;
  bit          timed_out, idle_after;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Coefficient port: registered read
  always @(posedge clk) bus.tap_rdata <= tap_mem[bus.tap_raddr];

  // Data BRAM: byte writes, registered read
  always @(posedge clk) begin
    if (bus.data_EN) begin
      for (int b = 0; b < 4; b++)
        if (bus.data_WE[b]) data_mem[bus.data_A[5:2]][8*b +: 8] <= bus.data_Di[8*b +: 8];
      bus.data_Do <= data_mem[bus.data_A[5:2]];
    end
  end

  // y[i] = sum_k tap[k] * x[i-k], zero history, low 32 bits
  function automatic logic [31:0] ref_out(input int i);
    longint s = 0;
    for (int k = 0; k < N; k++)
      if (i - k >= 0) s += longint'($signed(tap_mem[k])) * longint'($signed(in_v[i - k]));
    return s[31:0];
  endfunction

  // Runs one transfer of len samples from in_v, collecting outputs
  task automatic do_run(input int len, input int gap_pct, input int stall_pct);
    int  sent = 0;
    int  cyc = 0;
    bit  hs_in, hs_out;
    got_q.delete(); last_q.delete(); hs_in_cyc.delete();
    done_cnt = 0; timed_out = 0; first_valid_cyc = -1;
    @(posedge clk); #1;
    bus.ap_start = 1'b1; bus.data_length = len; bus.ss_tvalid = 1'b0; bus.sm_tready = 1'b0;
    @(posedge clk); #1;
    bus.ap_start = 1'b0; bus.data_length = $urandom;
    bus.ss_tvalid = (len > 0); bus.ss_tdata = (len > 0) ? in_v[0] : 32'h0;
    bus.sm_tready = ($urandom_range(0, 99) >= stall_pct);
    while (done_cnt == 0) begin
      @(negedge clk);
      cyc++;
      hs_in  = bus.ss_tvalid && bus.ss_tready;
      hs_out = bus.sm_tvalid && bus.sm_tready;
      if (bus.sm_tvalid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (hs_in) hs_in_cyc.push_back(cyc);
      if (hs_out) begin got_q.push_back(bus.sm_tdata); last_q.push_back(bus.sm_tlast); end
      if (bus.ap_done) done_cnt++;
      @(posedge clk); #1;
      if (hs_in) sent++;
      bus.ss_tvalid = (sent < len) && ($urandom_range(0, 99) >= gap_pct);
      bus.ss_tdata  = (sent < len) ? in_v[sent] : $urandom;
      bus.ss_tlast  = 1'($urandom_range(0, 1));
      bus.sm_tready = ($urandom_range(0, 99) >= stall_pct);
      if (cyc > 3000) begin timed_out = 1; break; end
    end
    @(negedge clk);
    if (bus.ap_done) done_cnt++;
    idle_after = bus.ap_idle;
    bus.ss_tvalid = 1'b0;
  endtask

  task automatic test_reset();
    bus.ap_start = 0; bus.data_length = 0; bus.ss_tvalid = 0; bus.ss_tdata = 0;
    bus.ss_tlast = 0; bus.sm_tready = 0;
    for (int i = 0; i < 16; i++) begin data_mem[i] = $urandom; tap_mem[i] = $urandom; end
    #12;
    n_cmp++;
    if ({bus.ap_idle, bus.ap_done, bus.ss_tready, bus.sm_tvalid, bus.sm_tlast} !== 5'b10000) begin
      n_bad++; $display("FAIL reset_ctrl got=%b want=10000",
        {bus.ap_idle, bus.ap_done, bus.ss_tready, bus.sm_tvalid, bus.sm_tlast});
    end
    n_cmp++;
    if ({bus.data_WE, bus.data_EN, bus.data_A, bus.data_Di, bus.tap_raddr, bus.sm_tdata} !== '0) begin
      n_bad++; $display("FAIL reset_bus got WE=%h EN=%b A=%h Di=%h raddr=%h tdata=%h want all 0",
        bus.data_WE, bus.data_EN, bus.data_A, bus.data_Di, bus.tap_raddr, bus.sm_tdata);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_ones();
    for (int k = 0; k < N; k++) tap_mem[k] = 32'd1;
    in_v = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    do_run(5, 0, 0);
    n_cmp++;
    if (timed_out || got_q.size() != 5) begin
      n_bad++; $display("FAIL ones_count got=%0d want=5 timeout=%0b", got_q.size(), timed_out);
    end
    for (int i = 0; i < got_q.size() && i < 5; i++) begin
      n_cmp++;
      if (got_q[i] !== ref_out(i) || last_q[i] !== (i == 4)) begin
        n_bad++; $display("FAIL ones_out[%0d] got=%0d last=%0b want=%0d last=%0b",
          i, got_q[i], last_q[i], ref_out(i), (i == 4));
      end
    end
    n_cmp++;
    if (done_cnt != 1 || idle_after !== 1'b1) begin
      n_bad++; $display("FAIL ones_done got pulses=%0d idle=%b want 1/1", done_cnt, idle_after);
    end
    n_cmp++;
    if (hs_in_cyc.size() < 2 || first_valid_cyc - hs_in_cyc[0] != N + 2 ||
        hs_in_cyc[1] - hs_in_cyc[0] != N + 3) begin
      n_bad++; $display("FAIL ones_timing got lat=%0d period=%0d want %0d/%0d",
        (hs_in_cyc.size() > 0) ? first_valid_cyc - hs_in_cyc[0] : -1,
        (hs_in_cyc.size() > 1) ? hs_in_cyc[1] - hs_in_cyc[0] : -1, N + 2, N + 3);
    end
  endtask

  task automatic test_ramp_wrap();
    for (int k = 0; k < N; k++) tap_mem[k] = k;
    in_v.delete();
    for (int i = 0; i < 12; i++) in_v.push_back(32'd1);
    do_run(12, 0, 0);
    n_cmp++;
    if (timed_out || got_q.size() != 12 || done_cnt != 1) begin
      n_bad++; $display("FAIL ramp_count got=%0d done=%0d want=12/1", got_q.size(), done_cnt);
    end
    for (int i = 0; i < got_q.size() && i < 12; i++) begin
      n_cmp++;
      if (got_q[i] !== ref_out(i) || last_q[i] !== (i == 11)) begin
        n_bad++; $display("FAIL ramp_out[%0d] got=%0d last=%0b want=%0d last=%0b",
          i, got_q[i], last_q[i], ref_out(i), (i == 11));
      end
    end
  endtask

  task automatic test_signed();
    for (int k = 0; k < N; k++) tap_mem[k] = (k == 0) ? 32'd1 : 32'd0;
    in_v = '{-32'sd5, 32'd7, 32'h7FFF_FFFF};
    do_run(3, 20, 20);
    n_cmp++;
    if (timed_out || got_q.size() != 3) begin
      n_bad++; $display("FAIL signed_count got=%0d want=3", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      n_cmp++;
      if (got_q[i] !== in_v[i]) begin
        n_bad++; $display("FAIL signed_out[%0d] got=%h want=%h", i, got_q[i], in_v[i]);
      end
    end
    for (int k = 0; k < N; k++) tap_mem[k] = 32'd2;
    in_v = '{32'h7FFF_FFFF};
    do_run(1, 0, 0);
    n_cmp++;
    if (timed_out || got_q.size() != 1 || got_q[0] !== 32'hFFFF_FFFE) begin
      n_bad++; $display("FAIL signed_wrap got=%h n=%0d want=fffffffe n=1",
        (got_q.size() > 0) ? got_q[0] : 32'hx, got_q.size());
    end
  endtask

  task automatic test_backpressure();
    bit ok = 0;
    int outs = 0;
    int dn = 0;
    logic [31:0] od = 0;
    bit ol = 0;
    for (int k = 0; k < N; k++) tap_mem[k] = 32'd1;
    @(posedge clk); #1;
    bus.ap_start = 1; bus.data_length = 2; bus.ss_tvalid = 1; bus.ss_tdata = 32'd3; bus.sm_tready = 0;
    @(posedge clk); #1;
    bus.ap_start = 0;
    for (int c = 0; c < 100 && !ok; c++) begin @(negedge clk); ok = bus.ss_tready; end
    @(posedge clk); #1; bus.ss_tdata = 32'd4;
    ok = 0;
    for (int c = 0; c < 100 && !ok; c++) begin @(negedge clk); ok = bus.sm_tvalid; end
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL bp_first_valid got=timeout want=sm_tvalid"); end
    for (int s = 0; s < 5; s++) begin
      if (s > 0) @(negedge clk);
      n_cmp++;
      if (bus.sm_tvalid !== 1'b1 || bus.sm_tdata !== 32'd3 || bus.ss_tready !== 1'b0 ||
          bus.sm_tlast !== 1'b0) begin
        n_bad++; $display("FAIL bp_stall[%0d] got v=%b d=%0d rdy=%b last=%b want 1/3/0/0",
          s, bus.sm_tvalid, bus.sm_tdata, bus.ss_tready, bus.sm_tlast);
      end
    end
    @(posedge clk); #1; bus.sm_tready = 1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (bus.sm_tvalid !== 1'b0) begin
      n_bad++; $display("FAIL bp_single got sm_tvalid=%b want=0", bus.sm_tvalid);
    end
    for (int c = 0; c < 100 && dn == 0; c++) begin
      @(negedge clk);
      if (bus.sm_tvalid && bus.sm_tready) begin outs++; od = bus.sm_tdata; ol = bus.sm_tlast; end
      if (bus.ap_done) dn++;
    end
    bus.ss_tvalid = 0;
    n_cmp++;
    if (outs != 1 || od !== 32'd7 || ol !== 1'b1 || dn != 1) begin
      n_bad++; $display("FAIL bp_second got n=%0d d=%0d last=%b done=%0d want 1/7/1/1",
        outs, od, ol, dn);
    end
  endtask

  task automatic test_second_run();
    int first = -1;
    int pulses = 0;
    int bad = 0;
    for (int k = 0; k < N; k++) tap_mem[k] = 32'd1;
    in_v = '{32'd10, 32'd10};
    do_run(2, 0, 0);
    n_cmp++;
    if (timed_out || got_q.size() != 2 || got_q[0] !== 32'd10 || got_q[1] !== 32'd20) begin
      n_bad++; $display("FAIL rerun_out got n=%0d first=%0d last=%0d want 2/10/20", got_q.size(),
        (got_q.size() > 0) ? got_q[0] : 0, (got_q.size() > 1) ? got_q[1] : 0);
    end
    @(posedge clk); #1;
    bus.ap_start = 1; bus.data_length = 0; bus.ss_tvalid = 1; bus.sm_tready = 1;
    @(posedge clk); #1;
    bus.ap_start = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (bus.ap_done) begin pulses++; if (first < 0) first = c; end
      if (bus.sm_tvalid || bus.ss_tready) bad++;
    end
    bus.ss_tvalid = 0;
    n_cmp++;
    if (first != N + 1 || pulses != 1 || bad != 0) begin
      n_bad++; $display("FAIL zero_len got done_at=%0d pulses=%0d stream=%0d want %0d/1/0",
        first, pulses, bad, N + 1);
    end
  endtask

  task automatic test_reset_mid_mac();
    bit ok = 0;
    for (int k = 0; k < N; k++) tap_mem[k] = $urandom | 32'h1;
    @(posedge clk); #1;
    bus.ap_start = 1; bus.data_length = 3; bus.ss_tvalid = 1; bus.ss_tdata = $urandom | 32'h1;
    bus.sm_tready = 1;
    @(posedge clk); #1;
    bus.ap_start = 0;
    for (int c = 0; c < 100 && !ok; c++) begin @(negedge clk); ok = bus.ss_tready; end
    @(posedge clk); #1; bus.ss_tvalid = 0;
    repeat (5) @(posedge clk);
    #2;
    n_cmp++;
    if (bus.ap_idle !== 1'b0 || bus.data_EN !== 1'b1) begin
      n_bad++; $display("FAIL mid_mac_busy got idle=%b en=%b want 0/1", bus.ap_idle, bus.data_EN);
    end
    #1; rst_n = 0; #1;
    n_cmp++;
    if ({bus.ap_idle, bus.ap_done, bus.ss_tready, bus.sm_tvalid, bus.sm_tlast} !== 5'b10000 ||
        {bus.data_WE, bus.data_EN, bus.data_A, bus.data_Di, bus.tap_raddr, bus.sm_tdata} !== '0) begin
      n_bad++; $display("FAIL async_reset got ctrl=%b A=%h raddr=%h tdata=%h EN=%b want 10000/0/0/0/0",
        {bus.ap_idle, bus.ap_done, bus.ss_tready, bus.sm_tvalid, bus.sm_tlast},
        bus.data_A, bus.tap_raddr, bus.sm_tdata, bus.data_EN);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    n_cmp++;
    if (bus.ap_idle !== 1'b1) begin
      n_bad++; $display("FAIL post_reset_idle got=%b want=1", bus.ap_idle);
    end
    in_v = '{$urandom, $urandom, $urandom};
    do_run(3, 25, 25);
    n_cmp++;
    if (timed_out || got_q.size() != 3) begin
      n_bad++; $display("FAIL post_reset_count got=%0d want=3", got_q.size());
    end
    for (int i = 0; i < got_q.size() && i < 3; i++) begin
      n_cmp++;
      if (got_q[i] !== ref_out(i)) begin
        n_bad++; $display("FAIL post_reset_out[%0d] got=%h want=%h", i, got_q[i], ref_out(i));
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int len = $urandom_range(1, 8);
      for (int k = 0; k < N; k++) tap_mem[k] = $urandom;
      in_v.delete();
      for (int i = 0; i < len; i++) in_v.push_back($urandom);
      do_run(len, 30, 30);
      n_cmp++;
      if (timed_out || got_q.size() != len || done_cnt != 1) begin
        n_bad++; $display("FAIL rand%0d_count got=%0d done=%0d want=%0d/1",
          r, got_q.size(), done_cnt, len);
      end
      for (int i = 0; i < got_q.size() && i < len; i++) begin
        n_cmp++;
        if (got_q[i] !== ref_out(i) || last_q[i] !== (i == len - 1)) begin
          n_bad++; $display("FAIL rand%0d_out[%0d] got=%h last=%b want=%h last=%b",
            r, i, got_q[i], last_q[i], ref_out(i), (i == len - 1));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_ramp_wrap();
    test_signed();
    test_backpressure();
    test_second_run();
    test_reset_mid_mac();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
